sram_two_port_stream: RTL and testbench
=======================================

Name: sram_two_port_stream

Overview:
- Parametrised two-port SRAM with per-lane write masks, deterministic read-during-write forwarding, and a valid/ready read interface with backpressure.
- The read side is decoupled by an internal response FIFO, so a consumer may stall without losing data.
- Sits between address generators and datapath consumers; the plain two-port macro wrapper remains the storage primitive beneath it.

Parameters:
- BW, 32, data width in bits; must be a multiple of NLANE.
- NDATA, 64, number of words; address width is $clog2(NDATA).
- NLANE, 4, write-mask lanes; each lane covers BW/NLANE bits.
- OUT_REG, 0, 0 or 1; extra read pipeline register; read latency L = 1+OUT_REG.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  reset; asynchronous, active-high.
- i_we  in  1  write strobe; never stalled.
- i_wmask  in  NLANE  lane enables; lane j writes bits [j*BW/NLANE +: BW/NLANE].
- i_waddr  in  $clog2(NDATA)  write address.
- i_wdata  in  BW  write data.
- i_rvalid  in  1  read request valid.
- o_rready  out  1  read request ready.
- i_raddr  in  $clog2(NDATA)  read address.
- o_dvalid  out  1  response valid.
- i_dready  in  1  response consumed.
- o_rdata  out  BW  response data (FIFO head).

Behaviour:
- Reset (async, active-high):
  - o_dvalid=0, o_rdata=0, o_rready=1 once i_rst deasserts; FIFO empty; credit count 0; pipe valids 0.
  - Memory contents are not reset.
  - Writes are ignored while i_rst=1.
  - Reset mid-operation discards in-flight and buffered reads.
- Write: at an edge with i_we=1, only the lanes with i_wmask[j]=1 update. i_wmask=0 leaves the word unchanged.
- Read accept: the edge where i_rvalid && o_rready. The array is read with i_raddr at that edge.
- Same-edge collision (accept and write to the same address): the response is the lane merge. Masked lanes return i_wdata; other lanes return the old contents. Never X.
- Later reads naturally observe completed writes.
- Latency:
  - Accept at edge k, FIFO empty, i_dready=1.
  - OUT_REG=0: o_dvalid=1 with data after edge k.
  - OUT_REG=1: o_dvalid=1 with data after edge k+1.
- Response FIFO:
  - Depth D = 2+OUT_REG.
  - Pop on o_dvalid && i_dready.
  - o_rdata holds its value while o_dvalid && !i_dready.
  - When empty, o_rdata holds the last popped value.
- Credit:
  - cnt = pipe occupancy + FIFO occupancy.
  - +1 per accept, -1 per pop, both on the same edge → unchanged.
  - o_rready = (cnt < D), driven from registers only; no combinational path from i_dready.
  - Guarantees no FIFO overflow.
  - With i_dready held at 1, one accept per cycle is sustained indefinitely.
- Boundaries:
  - cnt==D: o_rready=0; i_rvalid is ignored.
  - FIFO empty: no pop.
  - Simultaneous push and pop on a full FIFO cannot occur by the credit rule.
  - Pointers wrap modulo D.
  - Address ≥ NDATA with non-power-of-two NDATA is undefined.

Optional Feature:
- SRAM_PARITY_EN defined:
  - NLANE extra storage bits hold even parity per lane, computed on write and merged with the same lane rules.
  - Adds output o_perr [NLANE], aligned with o_rdata. It is set when the stored parity mismatches the recomputed parity, and is 0 at reset.
- Undefined: no parity storage and no o_perr port.

Decomposition:
- Shared package SramCfg gains:
  - function lane_merge(old, new, mask) returning BW bits.
  - constant RESP_DEPTH_BASE = 2.
  - parity helper function.
- Sub-module sram_resp_fifo(BW, DEPTH): synchronous FIFO with registered head, async reset, push/pop/count outputs.
- Storage is a behavioural array in this block.

Test Plan:
1. Reset, then write 0xDEADBEEF to addr 5 (mask 4'hF); read addr 5 with i_dready=1 → o_dvalid after the accept edge (OUT_REG=0), o_rdata=0xDEADBEEF; o_rready stays 1.
2. Addr 3 holds 0x11223344; on the same edge, write 0xAABBCCDD mask 4'b0101 and accept read 3 → o_rdata=0x11BB33DD; a subsequent read of 3 → 0x11BB33DD.
3. i_dready=0 with i_rvalid=1 continuously, OUT_REG=1 → exactly 3 accepts, then o_rready=0; raise i_dready → 3 responses in order, each held stable while stalled.
4. Back-to-back reads of addrs 0..15 with i_dready=1 → 16 accepts in 16 cycles; o_dvalid high every cycle after the first; data in address order.
5. Assert i_rst with 2 responses buffered and 1 in flight → immediately o_dvalid=0 and o_rdata=0; after release, o_rready=1; memory contents preserved.
6. SRAM_PARITY_EN: force-flip a stored bit in lane 2, then read → o_perr=4'b0100; a clean read → 0.

Source files
------------

// File: rtl/sram_two_port_stream_pkg.sv
// ---------------------------------------------------------------------------
// sram_two_port_stream_pkg
//   Shared configuration for the streaming two-port SRAM.
//   - RESP_DEPTH_BASE : response FIFO depth before the optional output register.
//   - SRAM_MAX_BW / SRAM_MAX_LANE : widest word / most lanes the helpers handle.
//     Callers zero-extend into these widths and size-cast the result back.
//   - lane_merge()  : per-lane select between an old word and a new word.
//   - lane_parity() : even parity bit per lane.
// ---------------------------------------------------------------------------
package sram_two_port_stream_pkg;

    localparam int RESP_DEPTH_BASE = 2;
    localparam int SRAM_MAX_BW     = 256;
    localparam int SRAM_MAX_LANE   = 32;

    // Lanes whose mask bit is set take new_word; all other bits keep old_word.
    // lane_w is the number of bits per lane.
    function automatic logic [SRAM_MAX_BW-1:0] lane_merge(
        input logic [SRAM_MAX_BW-1:0]   old_word,
        input logic [SRAM_MAX_BW-1:0]   new_word,
        input logic [SRAM_MAX_LANE-1:0] mask,
        input int                       lane_w
    );
        logic [SRAM_MAX_BW-1:0] merged;
        merged = old_word;
        for (int i = 0; i < SRAM_MAX_BW; i++) begin
            if (((i / lane_w) < SRAM_MAX_LANE) && mask[i / lane_w]) begin
                merged[i] = new_word[i];
            end
        end
        return merged;
    endfunction

    // Bit j is the XOR of all bits of lane j, so lane plus parity bit is even.
    function automatic logic [SRAM_MAX_LANE-1:0] lane_parity(
        input logic [SRAM_MAX_BW-1:0] word,
        input int                     lane_w
    );
        logic [SRAM_MAX_LANE-1:0] par;
        par = '0;
        for (int i = 0; i < SRAM_MAX_BW; i++) begin
            if ((i / lane_w) < SRAM_MAX_LANE) begin
                par[i / lane_w] = par[i / lane_w] ^ word[i];
            end
        end
        return par;
    endfunction

endpackage

// File: rtl/sram_two_port_stream_resp_fifo.sv
// ---------------------------------------------------------------------------
// sram_resp_fifo
//   Synchronous FIFO with a registered head word and asynchronous reset.
//   Ports:
//     i_clk, i_rst  clock (rising edge), async active-high reset
//     i_push        write i_pdata (ignored when full without a same-edge pop)
//     i_pdata       entry to push
//     i_pop         remove the head entry (ignored when empty)
//     o_head        registered head entry; holds the last popped value when
//                   empty, 0 after reset
//     o_count       number of stored entries
// ---------------------------------------------------------------------------
module sram_resp_fifo #(
    parameter int BW    = 32,
    parameter int DEPTH = 2
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_push,
    input  logic [BW-1:0]                i_pdata,
    input  logic                         i_pop,
    output logic [BW-1:0]                o_head,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [BW-1:0] store [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_next;
    logic          do_push;
    logic          do_pop;

    // Pointers wrap modulo DEPTH, which need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_pop  = i_pop && (o_count != '0);
    assign do_push = i_push && ((o_count != CW'(DEPTH)) || do_pop);
    assign rd_next = ptr_inc(rd_ptr);

    always_ff @(posedge i_clk) begin
        if (do_push) begin
            store[wr_ptr] <= i_pdata;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            o_count <= '0;
            o_head  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= rd_next;
            end
            if (do_push && !do_pop) begin
                o_count <= o_count + 1'b1;
            end else if (do_pop && !do_push) begin
                o_count <= o_count - 1'b1;
            end
            // The head register tracks store[rd_ptr]. A push into an empty
            // FIFO lands directly in the head; a pop loads the next stored
            // entry, or the incoming word when that was the only one left.
            if (do_push && (o_count == '0)) begin
                o_head <= i_pdata;
            end else if (do_pop) begin
                if (o_count > CW'(1)) begin
                    o_head <= store[rd_next];
                end else if (do_push) begin
                    o_head <= i_pdata;
                end
            end
        end
    end

endmodule

// File: rtl/sram_two_port_stream.sv
// ---------------------------------------------------------------------------
// sram_two_port_stream
//   Two-port SRAM with per-lane write masks, same-edge read/write forwarding
//   and a valid/ready read interface decoupled by a response FIFO.
//
//   Handshakes: a transfer happens on a rising edge where valid and ready are
//   both 1. Read requests transfer on i_rvalid && o_rready; responses transfer
//   on o_dvalid && i_dready. o_rready and o_dvalid come only from registers.
//
//   Ports:
//     i_clk, i_rst        clock, async active-high reset
//     i_we, i_wmask       write strobe and per-lane enables
//     i_waddr, i_wdata    write address / data
//     i_rvalid, o_rready  read request handshake
//     i_raddr             read address, sampled at the accept edge
//     o_dvalid, i_dready  response handshake
//     o_rdata             response data (FIFO head)
//     o_perr              per-lane parity error, aligned with o_rdata
//                         (only with SRAM_PARITY_EN defined)
//
//   Build option: define SRAM_PARITY_EN to store one even-parity bit per lane
//   and expose o_perr.
// ---------------------------------------------------------------------------
module sram_two_port_stream
    import sram_two_port_stream_pkg::*;
#(
    parameter int BW      = 32,
    parameter int NDATA   = 64,
    parameter int NLANE   = 4,
    parameter int OUT_REG = 0
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_we,
    input  logic [NLANE-1:0]         i_wmask,
    input  logic [$clog2(NDATA)-1:0] i_waddr,
    input  logic [BW-1:0]            i_wdata,
    input  logic                     i_rvalid,
    output logic                     o_rready,
    input  logic [$clog2(NDATA)-1:0] i_raddr,
    output logic                     o_dvalid,
    input  logic                     i_dready,
    output logic [BW-1:0]            o_rdata
`ifdef SRAM_PARITY_EN
    ,
    output logic [NLANE-1:0]         o_perr
`endif
);

    localparam int LANE_W = BW / NLANE;
    localparam int DEPTH  = RESP_DEPTH_BASE + OUT_REG;
    localparam int CW     = $clog2(DEPTH + 1);
`ifdef SRAM_PARITY_EN
    localparam int PB     = NLANE;
`else
    localparam int PB     = 0;
`endif
    localparam int EW     = BW + PB;

    logic [BW-1:0]    mem [NDATA];
    logic [NLANE-1:0] collide_mask;
    logic [BW-1:0]    wr_word;
    logic [BW-1:0]    rd_word;
    logic [EW-1:0]    rd_entry;
    logic             accept;
    logic             pop;
    logic             push;
    logic [EW-1:0]    push_data;
    logic [CW-1:0]    cnt;
    logic [EW-1:0]    fifo_head;
    logic [CW-1:0]    fifo_count;

    assign accept = i_rvalid && o_rready;
    assign pop    = o_dvalid && i_dready;

    // A read that hits the address being written on the same edge returns
    // the written lanes from i_wdata and the rest from the array.
    assign collide_mask = (i_we && (i_waddr == i_raddr)) ? i_wmask : '0;

    assign wr_word = BW'(lane_merge(SRAM_MAX_BW'(mem[i_waddr]), SRAM_MAX_BW'(i_wdata),
                                    SRAM_MAX_LANE'(i_wmask), LANE_W));
    assign rd_word = BW'(lane_merge(SRAM_MAX_BW'(mem[i_raddr]), SRAM_MAX_BW'(i_wdata),
                                    SRAM_MAX_LANE'(collide_mask), LANE_W));

    // Contents survive reset; only the write is suppressed while it is held.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
        end else if (i_we) begin
            mem[i_waddr] <= wr_word;
        end
    end

`ifdef SRAM_PARITY_EN
    logic [NLANE-1:0] par_mem [NDATA];
    logic [NLANE-1:0] wdata_par;
    logic [NLANE-1:0] wr_par;
    logic [NLANE-1:0] rd_par;
    logic [NLANE-1:0] head_par;

    // Parity bits follow the same lane rules as the data, one bit per lane.
    assign wdata_par = NLANE'(lane_parity(SRAM_MAX_BW'(i_wdata), LANE_W));
    assign wr_par    = NLANE'(lane_merge(SRAM_MAX_BW'(par_mem[i_waddr]), SRAM_MAX_BW'(wdata_par),
                                         SRAM_MAX_LANE'(i_wmask), 1));
    assign rd_par    = NLANE'(lane_merge(SRAM_MAX_BW'(par_mem[i_raddr]), SRAM_MAX_BW'(wdata_par),
                                         SRAM_MAX_LANE'(collide_mask), 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
        end else if (i_we) begin
            par_mem[i_waddr] <= wr_par;
        end
    end

    assign rd_entry = {rd_par, rd_word};
    assign head_par = fifo_head[EW-1:BW];
    // Reset clears the head to all zeros, which has consistent parity.
    assign o_perr   = head_par ^ NLANE'(lane_parity(SRAM_MAX_BW'(fifo_head[BW-1:0]), LANE_W));
`else
    assign rd_entry = rd_word;
`endif

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic          pipe_v;
            logic [EW-1:0] pipe_d;
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    pipe_v <= 1'b0;
                    pipe_d <= '0;
                end else begin
                    pipe_v <= accept;
                    if (accept) begin
                        pipe_d <= rd_entry;
                    end
                end
            end
            assign push      = pipe_v;
            assign push_data = pipe_d;
        end else begin : g_no_out_reg
            assign push      = accept;
            assign push_data = rd_entry;
        end
    endgenerate

    // Credits count every read that is in the pipe or in the FIFO, so a
    // request is only accepted when its response is guaranteed a FIFO slot.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt <= '0;
        end else if (accept && !pop) begin
            cnt <= cnt + 1'b1;
        end else if (pop && !accept) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign o_rready = (cnt < CW'(DEPTH));

    sram_resp_fifo #(
        .BW    (EW),
        .DEPTH (DEPTH)
    ) u_resp_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (push),
        .i_pdata (push_data),
        .i_pop   (pop),
        .o_head  (fifo_head),
        .o_count (fifo_count)
    );

    assign o_dvalid = (fifo_count != '0);
    assign o_rdata  = fifo_head[BW-1:0];

endmodule

// File: tb/tb_sram_two_port_stream.sv
// ---------------------------------------------------------------------------
// tb_sram_two_port_stream
//   Two instances share all inputs: u_dut0 with OUT_REG=0 (FIFO depth 2) and
//   u_dut1 with OUT_REG=1 (FIFO depth 3). A reference model keeps the memory
//   as a plain array and each instance's outstanding reads as a queue of
//   {data, cycle it becomes visible}; every cycle both instances are compared
//   against it, and directed sequences add explicit constant checks.
// ---------------------------------------------------------------------------
module tb_sram_two_port_stream;

    localparam int BW    = 32;
    localparam int NDATA = 64;
    localparam int NLANE = 4;
    localparam int AW    = 6;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic             we;
    logic [NLANE-1:0] wmask;
    logic [AW-1:0]    waddr;
    logic [BW-1:0]    wdata;
    logic             rvalid;
    logic [AW-1:0]    raddr;
    logic             dready;

    logic             rready0, dvalid0, rready1, dvalid1;
    logic [BW-1:0]    rdata0, rdata1;
`ifdef SRAM_PARITY_EN
    logic [NLANE-1:0] perr0, perr1;
`endif

    sram_two_port_stream #(.BW(BW), .NDATA(NDATA), .NLANE(NLANE), .OUT_REG(0)) u_dut0 (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_we     (we),
        .i_wmask  (wmask),
        .i_waddr  (waddr),
        .i_wdata  (wdata),
        .i_rvalid (rvalid),
        .o_rready (rready0),
        .i_raddr  (raddr),
        .o_dvalid (dvalid0),
        .i_dready (dready),
        .o_rdata  (rdata0)
`ifdef SRAM_PARITY_EN
        ,
        .o_perr   (perr0)
`endif
    );

    sram_two_port_stream #(.BW(BW), .NDATA(NDATA), .NLANE(NLANE), .OUT_REG(1)) u_dut1 (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_we     (we),
        .i_wmask  (wmask),
        .i_waddr  (waddr),
        .i_wdata  (wdata),
        .i_rvalid (rvalid),
        .o_rready (rready1),
        .i_raddr  (raddr),
        .o_dvalid (dvalid1),
        .i_dready (dready),
        .o_rdata  (rdata1)
`ifdef SRAM_PARITY_EN
        ,
        .o_perr   (perr1)
`endif
    );

    // ---------------- reference model ----------------
    typedef struct {
        logic [BW-1:0] d;
        int            t;
    } resp_t;

    resp_t         exp_q0[$];
    resp_t         exp_q1[$];
    logic [BW-1:0] last0, last1;
    logic [BW-1:0] ref_mem [NDATA];
    int            edge_no = 0;
    int            total   = 0;
    int            bad     = 0;

    function automatic logic [BW-1:0] merge_ref(input logic [BW-1:0] old_w,
                                                input logic [BW-1:0] nw,
                                                input logic [NLANE-1:0] m);
        logic [BW-1:0] r;
        r = old_w;
        for (int j = 0; j < NLANE; j++) begin
            if (m[j]) r[j*8 +: 8] = nw[j*8 +: 8];
        end
        return r;
    endfunction

    // Called just after each rising edge; inputs still hold their pre-edge values.
    task automatic model_edge();
        logic [BW-1:0] rd;
        logic          acc0, acc1;
        resp_t         r;
        edge_no++;
        if (rst) begin
            exp_q0.delete();
            exp_q1.delete();
            last0 = '0;
            last1 = '0;
            return;
        end
        rd   = merge_ref(ref_mem[raddr], wdata, (we && waddr == raddr) ? wmask : 4'h0);
        acc0 = rvalid && (exp_q0.size() < 2);
        acc1 = rvalid && (exp_q1.size() < 3);
        if (dready && exp_q0.size() > 0 && exp_q0[0].t < edge_no) begin
            last0 = exp_q0[0].d;
            void'(exp_q0.pop_front());
        end
        if (dready && exp_q1.size() > 0 && exp_q1[0].t < edge_no) begin
            last1 = exp_q1[0].d;
            void'(exp_q1.pop_front());
        end
        if (acc0) begin
            r.d = rd; r.t = edge_no;
            exp_q0.push_back(r);
        end
        if (acc1) begin
            r.d = rd; r.t = edge_no + 1;
            exp_q1.push_back(r);
        end
        if (we) ref_mem[waddr] = merge_ref(ref_mem[waddr], wdata, wmask);
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, edge_no, act, exp);
        end
    endtask

    task automatic compare_all();
        logic          v0, v1;
        logic [BW-1:0] d0, d1;
        v0 = (exp_q0.size() > 0) && (exp_q0[0].t <= edge_no);
        v1 = (exp_q1.size() > 0) && (exp_q1[0].t <= edge_no);
        d0 = v0 ? exp_q0[0].d : last0;
        d1 = v1 ? exp_q1[0].d : last1;
        check("rready0", 32'(rready0), 32'(exp_q0.size() < 2));
        check("dvalid0", 32'(dvalid0), 32'(v0));
        check("rdata0",  rdata0, d0);
        check("rready1", 32'(rready1), 32'(exp_q1.size() < 3));
        check("dvalid1", 32'(dvalid1), 32'(v1));
        check("rdata1",  rdata1, d1);
    endtask

    // ---------------- driver ----------------
    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        we = 1'b0; rvalid = 1'b0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    // ---------------- directed lane-merge table ----------------
    typedef struct {
        logic [AW-1:0]    addr;
        logic [BW-1:0]    init;
        logic [BW-1:0]    wd;
        logic [NLANE-1:0] mask;
        logic [BW-1:0]    exp;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{addr: 6'd3,  init: 32'h11223344, wd: 32'hAABBCCDD, mask: 4'b0101, exp: 32'h11BB33DD};
        vecs[1] = '{addr: 6'd12, init: 32'h11223344, wd: 32'hAABBCCDD, mask: 4'b1010, exp: 32'hAA22CC44};
        vecs[2] = '{addr: 6'd40, init: 32'h00000000, wd: 32'hFFFFFFFF, mask: 4'b1000, exp: 32'hFF000000};
        vecs[3] = '{addr: 6'd63, init: 32'hCAFEF00D, wd: 32'h12345678, mask: 4'b0001, exp: 32'hCAFEF078};
        vecs[4] = '{addr: 6'd0,  init: 32'h01020304, wd: 32'h55667788, mask: 4'b0000, exp: 32'h01020304};
        vecs[5] = '{addr: 6'd1,  init: 32'h00000000, wd: 32'h89ABCDEF, mask: 4'b1111, exp: 32'h89ABCDEF};

        rst = 1'b0; we = 1'b0; wmask = '0; waddr = '0; wdata = '0;
        rvalid = 1'b0; raddr = '0; dready = 1'b1;
        last0 = '0; last1 = '0;

        // Reset: outputs clear asynchronously.
        #2 rst = 1'b1;
        #1;
        check("rst_dvalid0", 32'(dvalid0), 32'd0);
        check("rst_rdata0",  rdata0, 32'd0);
        check("rst_dvalid1", 32'(dvalid1), 32'd0);
        check("rst_rdata1",  rdata1, 32'd0);
        cycle();
        cycle();
        rst = 1'b0;
        cycle();
        check("rst_rready0", 32'(rready0), 32'd1);

        // Fill memory with known values.
        for (int a = 0; a < NDATA; a++) begin
            we = 1'b1; wmask = 4'hF; waddr = AW'(a); wdata = $urandom;
            cycle();
        end
        idle(1);

        // Write then read back, OUT_REG=0 latency of one edge.
        we = 1'b1; wmask = 4'hF; waddr = 6'd5; wdata = 32'hDEADBEEF;
        cycle();
        we = 1'b0; rvalid = 1'b1; raddr = 6'd5;
        cycle();
        check("t1_dvalid", 32'(dvalid0), 32'd1);
        check("t1_rdata",  rdata0, 32'hDEADBEEF);
        check("t1_rready", 32'(rready0), 32'd1);
        idle(3);

        // Same-edge collisions, then a later read of the same word.
        for (int v = 0; v < 6; v++) begin
            we = 1'b1; wmask = 4'hF; waddr = vecs[v].addr; wdata = vecs[v].init; rvalid = 1'b0;
            cycle();
            wmask = vecs[v].mask; wdata = vecs[v].wd; rvalid = 1'b1; raddr = vecs[v].addr;
            cycle();
            check("t2_collide", rdata0, vecs[v].exp);
            we = 1'b0;
            cycle();
            check("t2_after", rdata0, vecs[v].exp);
            idle(3);
        end

        // Backpressure: depth-3 instance takes exactly 3 requests.
        dready = 1'b0; rvalid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            raddr = AW'(i);
            cycle();
        end
        check("t3_rready1", 32'(rready1), 32'd0);
        check("t3_rready0", 32'(rready0), 32'd0);
        rvalid = 1'b0; dready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("t3_order1", rdata1, ref_mem[i]);
            cycle();
        end
        idle(3);

        // Back-to-back reads of 0..15.
        dready = 1'b1; rvalid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            raddr = AW'(i);
            cycle();
            check("t4_dvalid0", 32'(dvalid0), 32'd1);
            check("t4_rdata0",  rdata0, ref_mem[i]);
            check("t4_rready0", 32'(rready0), 32'd1);
        end
        idle(4);

        // Reset with 2 buffered + 1 in flight; a write during reset is dropped.
        dready = 1'b0; rvalid = 1'b1;
        for (int i = 20; i < 23; i++) begin
            raddr = AW'(i);
            cycle();
        end
        rvalid = 1'b0;
        rst = 1'b1; we = 1'b1; wmask = 4'hF; waddr = 6'd7; wdata = 32'h0BAD0BAD;
        #1;
        check("t5_dvalid0", 32'(dvalid0), 32'd0);
        check("t5_rdata0",  rdata0, 32'd0);
        check("t5_dvalid1", 32'(dvalid1), 32'd0);
        check("t5_rdata1",  rdata1, 32'd0);
        cycle();
        rst = 1'b0; we = 1'b0; dready = 1'b1;
        cycle();
        check("t5_rready1", 32'(rready1), 32'd1);
        rvalid = 1'b1; raddr = 6'd7;
        cycle();
        check("t5_keep7", rdata0, ref_mem[7]);
        idle(3);

        // Randomized traffic with narrow address range for collisions.
        for (int i = 0; i < 400; i++) begin
            rst    = ($urandom_range(0, 99) == 0);
            we     = 1'($urandom_range(0, 1));
            wmask  = 4'($urandom_range(0, 15));
            waddr  = AW'($urandom_range(0, 7));
            wdata  = $urandom;
            rvalid = 1'($urandom_range(0, 1));
            raddr  = AW'($urandom_range(0, 7));
            dready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        rst = 1'b0; dready = 1'b1;
        idle(4);

`ifdef SRAM_PARITY_EN
        // Corrupt one stored data bit in lane 2 and read it back.
        u_dut0.mem[9][16] = ~u_dut0.mem[9][16];
        u_dut1.mem[9][16] = ~u_dut1.mem[9][16];
        ref_mem[9][16]    = ~ref_mem[9][16];
        rvalid = 1'b1; raddr = 6'd9;
        cycle();
        check("t6_perr0", 32'(perr0), 32'h4);
        raddr = 6'd10;
        cycle();
        check("t6_clean0", 32'(perr0), 32'h0);
        idle(3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
